// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
//   Shared encodings for the counter sequencer: the cmd_op command codes and
//   the sequencer FSM state type.
//   Ports: none (package).
package counter_seq_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10
    } state_t;

endpackage

// File: rtl/counter_core.sv
// counter_core
//   WIDTH-bit binary up/down counter with synchronous load. Load wins over
//   enable. Also exposes the value one step away in the selected direction,
//   so the controller can see where the next step lands without doing any
//   arithmetic of its own.
//   Ports:
//     clk, rst_n  - rising-edge clock, asynchronous active-low reset
//     en          - step the counter this edge
//     load        - load load_val this edge
//     load_val    - value to load
//     up          - step direction: 1 = +1, 0 = -1 (modulo 2^WIDTH)
//     count       - registered counter value
//     count_step  - count +/- 1 according to up (combinational)
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_step
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_step = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        count_d    = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Command-driven controller for counter_core. Accepts LOAD/RUN/PAUSE/ABORT
//   over a valid/ready handshake and steps the counter toward a latched
//   terminal value, pulsing done on the cycle the counter shows it.
//   Optional feature macro: COUNTER_SEQ_PRESCALE_EN adds the prescale port and
//   a tick counter so a step happens only every prescale+1 RUN cycles.
//   Ports:
//     clk, rst_n  - rising-edge clock, asynchronous active-low reset
//     cmd_valid   - command present
//     cmd_ready   - registered; high from the first edge after reset
//     cmd_op      - 00 LOAD, 01 RUN, 10 PAUSE, 11 ABORT
//     cmd_data    - load value (LOAD) or terminal value (RUN)
//     cmd_up      - RUN direction, 1 = up
//     prescale    - step interval minus 1 (prescaler builds only)
//     count       - current counter value
//     busy        - high in RUN or PAUSED
//     done        - one-cycle pulse when the terminal value is reached
//     cmd_err     - one-cycle pulse for a command illegal in the current state
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic                  cmd_up,
`ifdef COUNTER_SEQ_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cmd_err_q, cmd_err_d;
    logic             cmd_ready_q;

    logic             cmd_fire;
    logic             step;
    logic             core_en;
    logic             core_load;
    logic [WIDTH-1:0] count_step;

    assign cmd_fire = cmd_valid && cmd_ready_q;

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] tick_q, tick_d;
    assign step = (tick_q == prescale);
`else
    // PRESCALE_W only sizes the optional port; referenced here so the
    // parameter stays meaningful in builds without the prescaler.
    logic unused_prescale_w;
    assign unused_prescale_w = ^PRESCALE_W;
    assign step              = 1'b1;
`endif

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (core_en),
        .load       (core_load),
        .load_val   (cmd_data),
        .up         (dir_q),
        .count      (count),
        .count_step (count_step)
    );

    always_comb begin
        state_d   = state_q;
        term_d    = term_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        cmd_err_d = 1'b0;
        core_en   = 1'b0;
        core_load = 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
        tick_d    = tick_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_LOAD: core_load = 1'b1;
                        OP_RUN: begin
                            term_d = cmd_data;
                            dir_d  = cmd_up;
                            // Already at the terminal value: zero-length run.
                            if (count == cmd_data) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_RUN;
`ifdef COUNTER_SEQ_PRESCALE_EN
                                tick_d  = '0;
`endif
                            end
                        end
                        OP_PAUSE: cmd_err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // PAUSE and ABORT pre-empt any step due this cycle.
                if (cmd_fire && cmd_op == OP_PAUSE) begin
                    state_d = S_PAUSED;
                end else if (cmd_fire && cmd_op == OP_ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    cmd_err_d = cmd_fire;
                    if (step) begin
                        core_en = 1'b1;
`ifdef COUNTER_SEQ_PRESCALE_EN
                        tick_d  = '0;
`endif
                        // Completion owns this cycle's status: the dropped
                        // command is not reported alongside done.
                        if (count_step == term_q) begin
                            state_d   = S_IDLE;
                            done_d    = 1'b1;
                            cmd_err_d = 1'b0;
                        end
                    end else begin
`ifdef COUNTER_SEQ_PRESCALE_EN
                        tick_d = tick_q + PRESCALE_W'(1);
`endif
                    end
                end
            end
            S_PAUSED: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN:   state_d   = S_RUN;
                        OP_ABORT: state_d   = S_IDLE;
                        OP_LOAD:  cmd_err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            term_q      <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
            tick_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            term_q      <= term_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
            cmd_ready_q <= 1'b1;
`ifdef COUNTER_SEQ_PRESCALE_EN
            tick_q      <= tick_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Testbench for counter_sequencer: directed scenarios followed by random
//   command traffic compared against a behavioural model that tracks the
//   remaining step distance of each run.
//   Ports: none (top-level bench). Honours COUNTER_SEQ_PRESCALE_EN.
`timescale 1ns/1ps
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int WIDTH      = 4;
    localparam int PRESCALE_W = 8;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic [1:0]            cmd_op    = 2'b00;
    logic [WIDTH-1:0]      cmd_data  = '0;
    logic                  cmd_up    = 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale  = '0;
`endif
    logic                  cmd_ready;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;
    logic                  cmd_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_up    (cmd_up),
`ifdef COUNTER_SEQ_PRESCALE_EN
        .prescale  (prescale),
`endif
        .count     (count),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one edge.
    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic up);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_up    = up;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({count, busy, done, cmd_err, cmd_ready} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_values got count=%0d busy=%b done=%b err=%b ready=%b required all 0",
                     count, busy, done, cmd_err, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_rise got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_seq [4] = '{4'd6, 4'd7, 4'd8, 4'd9};
        send(OP_LOAD, 4'd5, 1'b1);
        checks++;
        if (count !== 4'd5 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load5 got count=%0d busy=%b required 5/0", count, busy);
        end
        send(OP_RUN, 4'd9, 1'b1);
        checks++;
        if (count !== 4'd5 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_accept got count=%0d busy=%b done=%b required 5/1/0", count, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== exp_seq[i] || done !== (i == 3) || busy !== (i != 3)) begin
                errors++;
                $display("[TB] FAIL up_step%0d got count=%0d done=%b busy=%b required %0d/%b/%b",
                         i, count, done, busy, exp_seq[i], (i == 3), (i != 3));
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || count !== 4'd9) begin
            errors++;
            $display("[TB] FAIL up_after got done=%b count=%0d required 0/9", done, count);
        end
    endtask

    task automatic test_wrap();
        int n_done = 0;
        send(OP_LOAD, 4'd14, 1'b1);
        send(OP_RUN, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) begin
                checks++;
                if (count !== 4'd0) begin
                    errors++;
                    $display("[TB] FAIL wrap_zero got %0d required 0", count);
                end
            end
            if (done === 1'b1) begin
                n_done++;
                checks++;
                if (count !== 4'd2 || i != 3) begin
                    errors++;
                    $display("[TB] FAIL wrap_done got count=%0d cycle=%0d required 2/3", count, i);
                end
            end
        end
        checks++;
        if (n_done != 1 || count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL wrap_pulses got %0d pulses count=%0d required 1/2", n_done, count);
        end
    endtask

    task automatic test_zero_length();
        send(OP_LOAD, 4'd3, 1'b0);
        send(OP_RUN, 4'd3, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL zero_len got done=%b busy=%b count=%0d required 1/0/3", done, busy, count);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL zero_len_after got done=%b busy=%b count=%0d required 0/0/3", done, busy, count);
        end
    endtask

    task automatic test_pause_resume();
        bit held = 1'b1;
        bit got_done = 1'b0;
        send(OP_LOAD, 4'd0, 1'b1);
        send(OP_RUN, 4'd10, 1'b1);
        repeat (4) tick();
        send(OP_PAUSE, 4'd0, 1'b0);
        checks++;
        if (count !== 4'd4 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_enter got count=%0d busy=%b required 4/1", count, busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (count !== 4'd4 || busy !== 1'b1 || done !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("[TB] FAIL pause_hold got count=%0d busy=%b required 4/1 throughout", count, busy);
        end
        send(OP_RUN, 4'd1, 1'b0);
        tick();
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("[TB] FAIL resume_dir got %0d required 5", count);
        end
        for (int i = 0; i < 10 && !got_done; i++) begin
            tick();
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (count !== 4'd10 || i != 4) begin
                    errors++;
                    $display("[TB] FAIL resume_done got count=%0d cycle=%0d required 10/4", count, i);
                end
            end
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("[TB] FAIL resume_timeout got no done required done within 10 cycles");
        end
    endtask

    task automatic test_errors();
        send(OP_LOAD, 4'd0, 1'b1);
        send(OP_RUN, 4'd15, 1'b1);
        tick();
        tick();
        send(OP_LOAD, 4'd9, 1'b1);
        checks++;
        if (cmd_err !== 1'b1 || count !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_load_in_run got err=%b count=%0d busy=%b required 1/3/1", cmd_err, count, busy);
        end
        tick();
        checks++;
        if (cmd_err !== 1'b0 || count !== 4'd4) begin
            errors++;
            $display("[TB] FAIL err_pulse_end got err=%b count=%0d required 0/4", cmd_err, count);
        end
        repeat (3) tick();
        send(OP_ABORT, 4'd0, 1'b0);
        checks++;
        if (count !== 4'd7 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort got count=%0d busy=%b done=%b required 7/0/0", count, busy, done);
        end
        tick();
        checks++;
        if (count !== 4'd7 || done !== 1'b0 || cmd_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_hold got count=%0d done=%b err=%b required 7/0/0", count, done, cmd_err);
        end
        send(OP_PAUSE, 4'd0, 1'b0);
        checks++;
        if (cmd_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_pause_idle got err=%b busy=%b required 1/0", cmd_err, busy);
        end
    endtask

    task automatic test_reset_midrun();
        send(OP_LOAD, 4'd0, 1'b1);
        send(OP_RUN, 4'd12, 1'b1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({count, busy, done, cmd_err, cmd_ready} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_midrun got count=%0d busy=%b done=%b err=%b ready=%b required all 0",
                     count, busy, done, cmd_err, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef COUNTER_SEQ_PRESCALE_EN
    task automatic test_prescale();
        prescale = 8'd2;
        send(OP_LOAD, 4'd0, 1'b1);
        send(OP_RUN, 4'd3, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            checks++;
            if (count !== 4'(c / 3) || done !== (c == 9)) begin
                errors++;
                $display("[TB] FAIL prescale_c%0d got count=%0d done=%b required %0d/%b",
                         c, count, done, c / 3, (c == 9));
            end
        end
        send(OP_LOAD, 4'd0, 1'b1);
        send(OP_RUN, 4'd3, 1'b1);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prescale_reset got count=%0d busy=%b done=%b required 0/0/0", count, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        prescale = 8'd0;
    endtask
`endif

    // Model: a run is tracked as a remaining step distance; done fires when
    // that distance is used up.
    task automatic test_random();
        int  m_cnt  = 0;
        int  m_rem  = 0;
        int  m_mode = 0;
        bit  m_up   = 1'b0;
        bit  v;
        int  op;
        int  d;
        bit  u;
        bit  e_done;
        bit  e_err;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 3);
            d  = $urandom_range(0, 15);
            u  = 1'($urandom_range(0, 1));
            cmd_valid = v;
            cmd_op    = 2'(op);
            cmd_data  = 4'(d);
            cmd_up    = u;
            e_done = 1'b0;
            e_err  = 1'b0;
            if (m_mode == 0) begin
                if (v && op == 0) m_cnt = d;
                if (v && op == 2) e_err = 1'b1;
                if (v && op == 1) begin
                    m_up  = u;
                    m_rem = u ? (d - m_cnt + 16) % 16 : (m_cnt - d + 16) % 16;
                    if (m_rem == 0) e_done = 1'b1;
                    else m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (v && op == 2) m_mode = 2;
                else if (v && op == 3) m_mode = 0;
                else begin
                    e_err = v;
                    m_cnt = (m_cnt + (m_up ? 1 : 15)) % 16;
                    m_rem--;
                    if (m_rem == 0) begin
                        e_done = 1'b1;
                        e_err  = 1'b0;
                        m_mode = 0;
                    end
                end
            end else begin
                if (v && op == 1) m_mode = 1;
                if (v && op == 3) m_mode = 0;
                if (v && op == 0) e_err = 1'b1;
            end
            tick();
            cmd_valid = 1'b0;
            checks++;
            if (count !== 4'(m_cnt) || busy !== (m_mode != 0) || done !== e_done || cmd_err !== e_err) begin
                errors++;
                $display("[TB] FAIL random_%0d got count=%0d busy=%b done=%b err=%b required %0d/%b/%b/%b",
                         n, count, busy, done, cmd_err, m_cnt, (m_mode != 0), e_done, e_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_zero_length();
        test_pause_resume();
        test_errors();
        test_reset_midrun();
`ifdef COUNTER_SEQ_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
